rgb_mixer_n: RTL

//   Parametrised N-channel encoder-to-PWM mixer; generalises the fixed 3-channel, 8-bit mixer top.

---
 rtl/rgb_mixer_n_if.sv | 28 ++
 rtl/rgb_mixer_n.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rgb_mixer_n_if.sv
// Encoder/PWM bundle for rgb_mixer_n: per-channel quadrature inputs, PWM outputs,
// packed level readback and the prescaler strobe.
interface rgb_mixer_n_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned WIDTH  = 8
);
  logic [NUM_CH-1:0]       enc_a;
  logic [NUM_CH-1:0]       enc_b;
  logic [NUM_CH-1:0]       pwm_out;
  logic [NUM_CH*WIDTH-1:0] level;
  logic                    tick;

  modport master (
    output enc_a,
    output enc_b,
    input  pwm_out,
    input  level,
    input  tick
  );

  modport slave (
    input  enc_a,
    input  enc_b,
    output pwm_out,
    output level,
    output tick
  );
endinterface

// File: rtl/rgb_mixer_n.sv
// N-channel quadrature-encoder to PWM mixer: synchronise, debounce on a prescaler tick,
// decode A rising edges into level steps, and compare levels against a shared PWM counter.
module rgb_mixer_n #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV_BITS = 8,
  parameter int unsigned HIST_LEN = 8,
  parameter int unsigned STEP     = 1,
  parameter bit          SATURATE = 1'b1
) (
  input logic          clk12_i,
  input logic          reset_ni,
  rgb_mixer_n_if.slave bus_io
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("rgb_mixer_n: NUM_CH must be >= 1");
  end
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("rgb_mixer_n: WIDTH must be in 2..16");
  end
  if (DIV_BITS < 1) begin : g_bad_div_bits
    $error("rgb_mixer_n: DIV_BITS must be >= 1");
  end
  if (HIST_LEN < 2) begin : g_bad_hist_len
    $error("rgb_mixer_n: HIST_LEN must be >= 2");
  end
  if (STEP < 1 || STEP > (2 ** WIDTH) - 1) begin : g_bad_step
    $error("rgb_mixer_n: STEP must be in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH:0]   StepW    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] LevelMax = '1;

  logic [DIV_BITS-1:0] div_q, div_d;
  logic                tick;

  logic [NUM_CH-1:0]   a_meta_q, a_sync_q, b_meta_q, b_sync_q;
  logic [HIST_LEN-1:0] hist_a_q [NUM_CH];
  logic [HIST_LEN-1:0] hist_a_d [NUM_CH];
  logic [HIST_LEN-1:0] hist_b_q [NUM_CH];
  logic [HIST_LEN-1:0] hist_b_d [NUM_CH];
  logic [NUM_CH-1:0]   db_a_q, db_a_d, db_b_q, db_b_d;
  logic [NUM_CH-1:0]   prev_a_q, prev_a_d;
  logic [NUM_CH-1:0]   pwm_q, pwm_d;
  logic [WIDTH-1:0]    level_q [NUM_CH];
  logic [WIDTH-1:0]    level_d [NUM_CH];
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]      up_sum  [NUM_CH];
  logic [WIDTH:0]      dn_diff [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] level_flat;

  assign tick = &div_q;

  always_comb begin
    div_d    = div_q + 1'b1;
    cnt_d    = cnt_q;
    db_a_d   = db_a_q;
    db_b_d   = db_b_q;
    prev_a_d = prev_a_q;
    pwm_d    = pwm_q;
    for (int i = 0; i < NUM_CH; i++) begin
      hist_a_d[i] = hist_a_q[i];
      hist_b_d[i] = hist_b_q[i];
      level_d[i]  = level_q[i];
      // The extra top bit flags overflow (up) or borrow (down) for saturation.
      up_sum[i]   = {1'b0, level_q[i]} + StepW;
      dn_diff[i]  = {1'b0, level_q[i]} - StepW;
    end
    if (tick) begin
      cnt_d    = cnt_q + 1'b1;
      prev_a_d = db_a_q;
      for (int i = 0; i < NUM_CH; i++) begin
        hist_a_d[i] = {hist_a_q[i][HIST_LEN-2:0], a_sync_q[i]};
        hist_b_d[i] = {hist_b_q[i][HIST_LEN-2:0], b_sync_q[i]};
        if (&hist_a_d[i]) begin
          db_a_d[i] = 1'b1;
        end else if (!(|hist_a_d[i])) begin
          db_a_d[i] = 1'b0;
        end
        if (&hist_b_d[i]) begin
          db_b_d[i] = 1'b1;
        end else if (!(|hist_b_d[i])) begin
          db_b_d[i] = 1'b0;
        end
        if (db_a_q[i] && !prev_a_q[i]) begin
          if (!db_b_q[i]) begin
            level_d[i] = (SATURATE && up_sum[i][WIDTH]) ? LevelMax : up_sum[i][WIDTH-1:0];
          end else begin
            level_d[i] = (SATURATE && dn_diff[i][WIDTH]) ? '0 : dn_diff[i][WIDTH-1:0];
          end
        end
        pwm_d[i] = (level_q[i] > cnt_q);
      end
    end
  end

  always_ff @(posedge clk12_i) begin
    if (!reset_ni) begin
      div_q    <= '0;
      a_meta_q <= '0;
      a_sync_q <= '0;
      b_meta_q <= '0;
      b_sync_q <= '0;
      db_a_q   <= '0;
      db_b_q   <= '0;
      prev_a_q <= '0;
      pwm_q    <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hist_a_q[i] <= '0;
        hist_b_q[i] <= '0;
        level_q[i]  <= '0;
      end
    end else begin
      div_q    <= div_d;
      a_meta_q <= bus_io.enc_a;
      a_sync_q <= a_meta_q;
      b_meta_q <= bus_io.enc_b;
      b_sync_q <= b_meta_q;
      db_a_q   <= db_a_d;
      db_b_q   <= db_b_d;
      prev_a_q <= prev_a_d;
      pwm_q    <= pwm_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        hist_a_q[i] <= hist_a_d[i];
        hist_b_q[i] <= hist_b_d[i];
        level_q[i]  <= level_d[i];
      end
    end
  end

  always_comb begin
    level_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      level_flat[i*WIDTH +: WIDTH] = level_q[i];
    end
  end

  assign bus_io.level   = level_flat;
  assign bus_io.pwm_out = pwm_q;
  assign bus_io.tick    = tick;

endmodule
